// File: rtl/callret_pkg.sv
// Shared definitions for the call/return sequencer: default stack geometry,
// the depth-counter width and the sequencer FSM state encoding.
package callret_pkg;

   localparam int DEPTH_DEF   = 16;
   localparam int WIDTH_DEF   = 32;
   localparam int DEPTH_W_DEF = $clog2(DEPTH_DEF) + 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PUSH     = 3'd1,
      ST_POP      = 3'd2,
      ST_POP_WAIT = 3'd3,
      ST_DONE     = 3'd4,
      ST_ERR      = 3'd5
   } state_t;

endpackage

// File: rtl/callret_depth_ctr.sv
// Saturating up/down counter tracking how many entries sit in the
// return-address stack, with full/empty flags for the overflow guard.
module callret_depth_ctr
   import callret_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inc,
   input  logic                   dec,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int DW = $clog2(DEPTH) + 1;

   // Count pushes up and pops down, clamping at 0 and DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && count != DW'(DEPTH)) begin
         count <= count + 1'b1;
      end else if (dec && !inc && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign full  = (count == DW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/call_ret_unit.sv
// Call/return sequencer driving the push/pop strobes of a LIFO
// return-address stack and producing one done pulse per request.
// Optional feature macro: CALLRET_GUARD_EN (overflow/underflow guard backed
// by a depth counter). Without it requests are forwarded unconditionally,
// depth reads 0 and err only flags simultaneous CALL+RET.
module call_ret_unit
   import callret_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   call_req,
   input  logic                   ret_req,
   input  logic [WIDTH-1:0]       pc_in,
   input  logic [WIDTH-1:0]       call_target,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [WIDTH-1:0]       next_pc,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   stk_write_en,
   output logic                   stk_read_en,
   output logic [WIDTH-1:0]       stk_data_in,
   input  logic [WIDTH-1:0]       stk_data_out
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] ret_addr;
   logic [WIDTH-1:0] target;
   logic             full;
   logic             empty;

   // Return address is PC+1, wrapping modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] addr_inc(input logic [WIDTH-1:0] a);
      return a + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

`ifdef CALLRET_GUARD_EN
   callret_depth_ctr #(.DEPTH(DEPTH)) u_depth_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (state == ST_PUSH),
      .dec   (state == ST_POP),
      .count (depth),
      .full  (full),
      .empty (empty)
   );
`else
   assign full  = 1'b0;
   assign empty = 1'b0;
   assign depth = '0;
`endif

   // Next-state decode; requests are only looked at while idle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (call_req && ret_req)  state_nxt = ST_ERR;
            else if (call_req)        state_nxt = full  ? ST_ERR : ST_PUSH;
            else if (ret_req)         state_nxt = empty ? ST_ERR : ST_POP;
         end
         ST_PUSH:     state_nxt = ST_DONE;
         ST_POP:      state_nxt = ST_POP_WAIT;
         ST_POP_WAIT: state_nxt = ST_DONE;
         ST_DONE:     state_nxt = ST_IDLE;
         ST_ERR:      state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // State register; async reset aborts any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Latch request operands in IDLE and update next_pc only on entry to DONE/ERR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ret_addr <= '0;
         target   <= '0;
         next_pc  <= '0;
      end else begin
         if (state == ST_IDLE && (call_req || ret_req)) begin
            ret_addr <= addr_inc(pc_in);
            target   <= call_target;
         end
         if (state == ST_IDLE && state_nxt == ST_ERR) begin
            next_pc <= addr_inc(pc_in);
         end else if (state == ST_PUSH) begin
            next_pc <= target;
         end else if (state == ST_POP_WAIT) begin
            next_pc <= stk_data_out;
         end
      end
   end

   // Outputs decode straight from the state register, so reset drops them at once.
   assign busy         = (state != ST_IDLE);
   assign done         = (state == ST_DONE) || (state == ST_ERR);
   assign err          = (state == ST_ERR);
   assign stk_write_en = (state == ST_PUSH);
   assign stk_read_en  = (state == ST_POP);
   assign stk_data_in  = ret_addr;

endmodule

// File: doc/call_ret_unit.md
# call_ret_unit

Call/return sequencer that sits directly upstream of the 16-entry LIFO return-address stack and drives its push/pop strobes. On a CALL it pushes the return address (PC+1) and redirects to the call target. On a RET it pops the stack and returns the popped address as the next PC. It runs a small FSM so the PC-update logic sees exactly one `done` pulse per request, plus an optional overflow/underflow guard.

## Interface
- `DEPTH`, 16: stack capacity in entries; must match the downstream stack.
- `WIDTH`, 32: address/data width; must match the stack data width.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `call_req`  in  1: CALL request; sampled only in IDLE.
- `ret_req`  in  1: RET request; sampled only in IDLE.
- `pc_in`  in  WIDTH: PC of the CALL/RET instruction.
- `call_target`  in  WIDTH: jump target for CALL.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when `next_pc` is valid.
- `err`  out  1: one-cycle pulse, coincident with `done`, on a rejected request.
- `next_pc`  out  WIDTH: registered redirect address; holds until the next `done`.
- `depth`  out  $clog2(DEPTH)+1: current number of stacked entries.
- `stk_write_en`  out  1: push strobe to the stack.
- `stk_read_en`  out  1: pop strobe to the stack.
- `stk_data_in`  out  WIDTH: push data to the stack.
- `stk_data_out`  in  WIDTH: pop data from the stack; valid the cycle after the pop edge.

## Operation
- FSM states: IDLE, PUSH, POP, POP_WAIT, DONE, ERR.
- IDLE:
  - `call_req` alone: latch `pc_in+1` and `call_target`, then go to PUSH. With the guard compiled in and `depth==DEPTH`, go to ERR instead.
  - `ret_req` alone: go to POP. With the guard compiled in and `depth==0`, go to ERR instead.
  - Both requests high: go to ERR; no stack strobe is issued.
- PUSH: `stk_write_en=1`, `stk_data_in`=latched `pc_in+1`. Increment `depth` at the exiting edge. `next_pc`<=`call_target`. Go to DONE.
- POP: `stk_read_en=1`. Decrement `depth` at the exiting edge. Go to POP_WAIT.
- POP_WAIT: `next_pc`<=`stk_data_out`. Go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- ERR: `done=1` and `err=1` for one cycle. `next_pc`<=latched `pc_in+1`, so execution falls through. `depth` is unchanged. Then IDLE.
- `stk_write_en` and `stk_read_en` are mutually exclusive and never high for more than one cycle per request.
- Requests arriving while `busy` are ignored; the requester holds them until `done`.
- Arithmetic: `pc_in+1` is taken modulo 2^WIDTH, so all-ones wraps to 0. `depth` never exceeds DEPTH and never goes below 0.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `done`, `err` = 0
  - `stk_write_en`, `stk_read_en` = 0
  - `stk_data_in`, `next_pc` = 0
  - `depth` = 0
- Reset mid-operation aborts immediately and drops strobes asynchronously. The stack has no reset, so `rst` is only asserted together with system initialisation; a pop in flight is lost.
- Latencies, with the request sampled at edge 0:
  - CALL: push strobe during cycle 1; `done` during cycle 2. Back-to-back CALLs complete every 3 cycles.
  - RET: pop strobe during cycle 1; `stk_data_out` captured at the end of cycle 2; `done` during cycle 3.
  - ERR: `done`+`err` during cycle 1.
- `next_pc` changes only on the edge that enters DONE or ERR.

## Configuration
- `CALLRET_GUARD_EN` defined:
  - The depth counter checks fullness and emptiness.
  - CALL when full, RET when empty, or both requests together → ERR.
- `CALLRET_GUARD_EN` undefined:
  - Requests are forwarded unconditionally.
  - `depth` is tied to 0 and `err` pulses only on simultaneous requests.
  - The stack's own sp bounds silently drop the operation.

## Structure
- Package `callret_pkg` holds:
  - the FSM state enum;
  - the DEPTH/WIDTH defaults;
  - the depth-width constant `$clog2(DEPTH)+1`.
- One sub-module, `callret_depth_ctr`: saturating up/down counter with `full`/`empty` flags, instantiated only under `CALLRET_GUARD_EN`.

## Test plan
- Reset, then CALL with `pc_in=0x100`, `call_target=0x400` → `stk_write_en` 1 cycle with `stk_data_in=0x101`; `done` at cycle 2 with `next_pc=0x400`; `depth=1`.
- After that CALL, RET → `stk_read_en` 1 cycle; `done` at cycle 3 with `next_pc=0x101`; `depth=0`.
- 16 CALLs with `pc_in`=0..15, then a 17th (guard on) → 17th gives `err`+`done` with `next_pc=pc_in+1`, no strobe, `depth=16`. Then 16 RETs return 16..1 in LIFO order.
- RET at `depth=0` (guard on) → `err` pulse, no `stk_read_en`, `depth` stays 0.
- `call_req` and `ret_req` high together → `err` pulse and no strobes. A request held during `busy` is not double-issued.
- CALL with `pc_in=0xFFFFFFFF` → pushed value 0x00000000. Assert `rst` during POP → strobes drop immediately; `busy`=0 and `depth`=0.
